sumador_serial_ctrl: RTL and testbench

//   Bit-serial adder controller: time-multiplexes one full-adder cell (two half-adder

---
 rtl/sumador_serial_ctrl_pkg.sv | 22 ++
 rtl/sumador_serial_ctrl_celda.sv | 20 ++
 rtl/sumador_serial_ctrl.sv | 121 ++++++++++++
 tb/tb_sumador_serial_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sumador_serial_ctrl_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and a half-adder helper.
package sumador_serial_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic s;
        logic c;
    } haOut_t;

    function automatic haOut_t halfAdd(input logic x, input logic y);
        haOut_t r;
        r.s = x ^ y;
        r.c = x & y;
        return r;
    endfunction

endpackage

// File: rtl/sumador_serial_ctrl_celda.sv
// One-bit full adder built from two half-adder stages and an OR of their carries.
module celda_sumador_completo
    import sumador_serial_ctrl_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    haOut_t stage1;
    haOut_t stage2;

    assign stage1 = halfAdd(x, y);
    assign stage2 = halfAdd(stage1.s, cin);
    assign s      = stage2.s;
    assign co     = stage1.c | stage2.c;

endmodule

// File: rtl/sumador_serial_ctrl.sv
// Bit-serial adder: one shared full-adder cell walks the operands LSB first, one bit per clock.
module sumador_serial_ctrl
    import sumador_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             nextState;
    logic [WIDTH-1:0]   shA;
    logic [WIDTH-1:0]   shB;
    logic [WIDTH-1:0]   shS;
    logic [WIDTH-1:0]   shSNext;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               sBit;
    logic               cBit;
    logic               lastBit;
    logic               busyNext;
    logic               doneNext;

    celda_sumador_completo uCelda (
        .x   (shA[0]),
        .y   (shB[0]),
        .cin (carry),
        .s   (sBit),
        .co  (cBit)
    );

    assign lastBit = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nextState;
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  if (start)   nextState = S_RUN;
            S_RUN:   if (lastBit) nextState = S_DONE;
            S_DONE:               nextState = S_IDLE;
            default:              nextState = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state and registered, so they never glitch.
    always_comb begin
        busyNext = (nextState == S_RUN);
        doneNext = (nextState == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busyNext;
            done <= doneNext;
        end
    end

    // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
    always_comb begin
        shSNext            = shS >> 1;
        shSNext[WIDTH-1]   = sBit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shA   <= '0;
            shB   <= '0;
            shS   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shA   <= a;
                        shB   <= b;
                        shS   <= '0;
                        cnt   <= '0;
                        carry <= 1'b0;
                    end
                end
                S_RUN: begin
                    shA   <= shA >> 1;
                    shB   <= shB >> 1;
                    shS   <= shSNext;
                    carry <= cBit;
                    if (lastBit) begin
                        cnt  <= '0;
                        sum  <= shSNext;
                        cout <= cBit;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_serial_ctrl.sv
// Bench for sumador_serial_ctrl at WIDTH=8, 13 and 1 with a per-instance result scoreboard.
module tb_sumador_serial_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start8 = 1'b0,  start13 = 1'b0, start1 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [12:0] a13 = '0, b13 = '0;
    logic [0:0]  a1 = '0, b1 = '0;
    logic        busy8, done8, cout8;
    logic        busy13, done13, cout13;
    logic        busy1, done1, cout1;
    logic [7:0]  sum8;
    logic [12:0] sum13;
    logic [0:0]  sum1;

    int total = 0;
    int bad   = 0;
    int doneCount8 = 0;

    logic [8:0]  q8[$];
    logic [13:0] q13[$];
    logic [1:0]  q1[$];
    logic [8:0]  e8;
    logic [13:0] e13;
    logic [1:0]  e1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expSum;
        logic       expCout;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    sumador_serial_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    sumador_serial_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13),
        .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
    );

    sumador_serial_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            doneCount8++;
            check("sb8Pending", 32'(q8.size() > 0), 32'd1);
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                check("sb8Result", 32'({cout8, sum8}), 32'(e8));
            end
        end
    end

    always @(negedge clk) begin
        if (done13 === 1'b1) begin
            check("sb13Pending", 32'(q13.size() > 0), 32'd1);
            if (q13.size() > 0) begin
                e13 = q13.pop_front();
                check("sb13Result", 32'({cout13, sum13}), 32'(e13));
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            check("sb1Pending", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check("sb1Result", 32'({cout1, sum1}), 32'(e1));
            end
        end
    end

    task automatic drive(input int id, input logic s, input logic [31:0] av, input logic [31:0] bv);
        case (id)
            8:  begin start8  = s; a8  = av[7:0];  b8  = bv[7:0];  end
            13: begin start13 = s; a13 = av[12:0]; b13 = bv[12:0]; end
            default: begin start1 = s; a1 = av[0:0]; b1 = bv[0:0]; end
        endcase
    endtask

    task automatic pushExp(input int id, input logic [31:0] av, input logic [31:0] bv);
        case (id)
            8:  q8.push_back({1'b0, av[7:0]} + {1'b0, bv[7:0]});
            13: q13.push_back({1'b0, av[12:0]} + {1'b0, bv[12:0]});
            default: q1.push_back({1'b0, av[0]} + {1'b0, bv[0]});
        endcase
    endtask

    function automatic logic getBusy(input int id);
        case (id)
            8:       return busy8;
            13:      return busy13;
            default: return busy1;
        endcase
    endfunction

    function automatic logic getDone(input int id);
        case (id)
            8:       return done8;
            13:      return done13;
            default: return done1;
        endcase
    endfunction

    // One add: pulse start for one cycle, count busy cycles, land on the done cycle.
    task automatic runAdd(input int id, input logic [31:0] av, input logic [31:0] bv, input int width);
        int cycles;
        @(negedge clk);
        drive(id, 1'b1, av, bv);
        pushExp(id, av, bv);
        @(negedge clk);
        drive(id, 1'b0, av, bv);
        cycles = 0;
        while (getBusy(id) && cycles < 64) begin
            cycles++;
            @(negedge clk);
        end
        check($sformatf("busyLen%0d", id), 32'(cycles), 32'(width));
        check($sformatf("doneHigh%0d", id), 32'(getDone(id)), 32'd1);
    endtask

    initial begin
        int cycles;
        int doneBefore;

        vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[5] = '{8'h01, 8'h7F, 8'h80, 1'b0};

        repeat (2) @(negedge clk);
        check("rstBusy", 32'({busy8, busy13, busy1}), 32'd0);
        check("rstDone", 32'({done8, done13, done1}), 32'd0);
        check("rstSum8", 32'(sum8), 32'd0);
        check("rstCout8", 32'(cout8), 32'd0);
        check("rstSum13", 32'({cout13, sum13}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            runAdd(8, 32'(vecs[i].a), 32'(vecs[i].b), 8);
            check("vecSum", 32'(sum8), 32'(vecs[i].expSum));
            check("vecCout", 32'(cout8), 32'(vecs[i].expCout));
            @(negedge clk);
            check("doneLow", 32'(done8), 32'd0);
        end

        // Back-to-back: start in the first IDLE cycle; sum holds 0x96 throughout RUN.
        runAdd(8, 32'h5A, 32'h3C, 8);
        @(negedge clk);
        drive(8, 1'b1, 32'hFF, 32'h01);
        pushExp(8, 32'hFF, 32'h01);
        @(negedge clk);
        drive(8, 1'b0, 32'h0, 32'h0);
        cycles = 0;
        while (busy8 && cycles < 64) begin
            check("holdSum", 32'({cout8, sum8}), 32'h096);
            cycles++;
            @(negedge clk);
        end
        check("b2bBusyLen", 32'(cycles), 32'd8);
        check("b2bSum", 32'({cout8, sum8}), 32'h100);

        // start held high with changing operands during RUN and DONE is ignored.
        @(negedge clk);
        drive(8, 1'b1, 32'h5A, 32'h3C);
        pushExp(8, 32'h5A, 32'h3C);
        @(negedge clk);
        cycles = 0;
        while (busy8 && cycles < 64) begin
            drive(8, 1'b1, 32'(8'h11 + cycles), 32'h22);
            cycles++;
            @(negedge clk);
        end
        check("heldBusyLen", 32'(cycles), 32'd8);
        check("heldSum", 32'(sum8), 32'h96);
        drive(8, 1'b1, 32'h11, 32'h22);
        @(negedge clk);
        check("heldIdle", 32'(busy8), 32'd0);
        pushExp(8, 32'h11, 32'h22);
        @(negedge clk);
        check("heldAccept", 32'(busy8), 32'd1);
        drive(8, 1'b0, 32'h0, 32'h0);
        cycles = 0;
        while (!done8 && cycles < 64) begin
            cycles++;
            @(negedge clk);
        end
        check("heldSecond", 32'(sum8), 32'h33);

        // Reset in RUN cycle 4: abort, clear results, no done pulse, then recover.
        @(negedge clk);
        drive(8, 1'b1, 32'h5A, 32'h3C);
        @(negedge clk);
        drive(8, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("preRstBusy", 32'(busy8), 32'd1);
        doneBefore = doneCount8;
        rst = 1'b1;
        #1;
        check("abortBusy", 32'(busy8), 32'd0);
        check("abortDone", 32'(done8), 32'd0);
        check("abortSum", 32'({cout8, sum8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abortNoDone", 32'(doneCount8 - doneBefore), 32'd0);
        runAdd(8, 32'hFF, 32'hFF, 8);
        check("postRstSum", 32'({cout8, sum8}), 32'h1FE);

        // WIDTH=1 corner.
        runAdd(1, 32'd1, 32'd1, 1);
        check("w1Sum", 32'(sum1), 32'd0);
        check("w1Cout", 32'(cout1), 32'd1);
        runAdd(1, 32'd1, 32'd0, 1);
        check("w1Sum10", 32'({cout1, sum1}), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            runAdd(8, $urandom, $urandom, 8);
            runAdd(13, $urandom, $urandom, 13);
        end

        @(negedge clk);
        check("q8Empty", 32'(q8.size()), 32'd0);
        check("q13Empty", 32'(q13.size()), 32'd0);
        check("q1Empty", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
